sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
//
// PURPOSE
// - Shares the single SDRAM controller Avalon-MM slave (32-bit, 16M x 32 words) between two masters:
//   m0 = USB DMA engine (priority), m1 = Nios II data master bridge.
// - Pipelined reads: routes each s_readdatavalid beat back to the master that issued it, in issue order.
// - Sits between the system interconnect and the SDRAM controller; no clock crossing.
//
// PARAMETERS
// ADDR_W    24  word address width (13 row + 2 bank + 9 col)
// DATA_W    32  data width; byteenable is DATA_W/8
// MAX_PEND  8   max outstanding reads (power of 2), depth of return-ID FIFO
// MAX_HOLD  16  max consecutive accepted commands for one master while the other is requesting
//
// PORTS
// clk_clk               in   1        system clock (same domain as sys_clk_out_clk)
// reset_reset           in   1        synchronous, active-high reset
// m{0,1}_address        in   ADDR_W   master word address
// m{0,1}_read           in   1        read request
// m{0,1}_write          in   1        write request
// m{0,1}_writedata      in   DATA_W   write data
// m{0,1}_byteenable     in   DATA_W/8 byte lanes
// m{0,1}_waitrequest    out  1        command not accepted this cycle
// m{0,1}_readdata       out  DATA_W   returned read data
// m{0,1}_readdatavalid  out  1        read beat for this master
// s_address/read/write/writedata/byteenable  out  as above   to SDRAM controller
// s_waitrequest         in   1        controller stall
// s_readdata            in   DATA_W   controller read data
// s_readdatavalid       in   1        controller read beat
// err_orphan_rdv        out  1        sticky: readdatavalid arrived with empty return FIFO
//
// BEHAVIOUR
// - Registered state: grant (0/1), lock, hold_cnt, return FIFO (ids, wr/rd ptr, count), err flag.
// - Reset: grant=0, lock=0, hold_cnt=0, FIFO empty, err_orphan_rdv=0; during reset s_read=s_write=0,
//   m0/m1_waitrequest=1, m0/m1_readdatavalid=0.
// - Command path combinational: s_* = granted master's signals; granted m_waitrequest = s_waitrequest
//   (or 1 when stalled, below); non-granted m_waitrequest=1. Zero added latency.
// - Accept = granted (read|write) & ~s_waitrequest & ~stall. Read & write both high: treated as write.
// - Stall: granted read while FIFO count==MAX_PEND -> s_read=0, m_waitrequest=1; writes never stall.
// - lock=1 from first cycle a command is presented but not accepted, until accepted: grant frozen,
//   so s_* is never withdrawn mid-command.
// - Arbitration (evaluated when lock=0, at cycle end, takes effect next cycle):
//   - only one master requesting -> grant to it; neither -> keep grant.
//   - both requesting -> keep current unless hold_cnt reaches MAX_HOLD-1 on this accept, then switch.
//   - tie at idle (neither granted-active, both request): m0 wins.
// - hold_cnt: +1 per accept while other master requests; cleared on grant switch; saturates.
// - Return FIFO: push grant id on accepted read; pop on s_readdatavalid; head id selects
//   m{id}_readdatavalid=1, readdata to both masters = s_readdata. Same-cycle push+pop: count unchanged.
// - Readdatavalid with count==0: drop beat, set err_orphan_rdv (cleared only by reset).
// - Reset mid-operation: FIFO flushed; SDRAM controller is reset by the same reset bridge.
//
// STRUCTURE
// - Package sdram_arb_pkg: master_id_t (1 bit), localparam BE_W=DATA_W/8, PTR_W=$clog2(MAX_PEND).
// - Sub-module rd_id_fifo: MAX_PEND x 1-bit sync FIFO, count-based full/empty, push+pop same cycle.
// - Top: grant/lock/hold_cnt FSM + combinational muxes; no other hierarchy.
//
// TESTING
// - m0 write 0x000100 data 0xDEADBEEF be 0xF, m1 idle -> s_write same cycle, m0_waitrequest follows s.
// - m0,m1 reads issued together at reset idle -> m0 granted first; data beats return to m0 then m1 in order.
// - Both masters streaming writes, s_waitrequest=0 -> grant switches after exactly 16 m0 accepts.
// - s_waitrequest held 5 cycles on m1 read while m0 requests -> grant stays m1, s_address stable until accept.
// - 8 reads outstanding, no rdv -> 9th read stalled (s_read=0); one rdv -> 9th accepted same cycle.
// - s_readdatavalid with empty FIFO -> no m*_readdatavalid, err_orphan_rdv=1 until reset_reset.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and sizing for the two-master SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  localparam int ARB_DATA_W   = 32;
  localparam int ARB_MAX_PEND = 8;
  localparam int BE_W         = ARB_DATA_W / 8;
  localparam int PTR_W        = $clog2(ARB_MAX_PEND);

  function automatic master_id_t other_id(input master_id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/rd_id_fifo.sv
// Return-ID FIFO: remembers which master issued each outstanding read, in issue order.
module rd_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = ARB_MAX_PEND,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  master_id_t din,
  output master_id_t dout,
  output logic       full,
  output logic       empty
);

  master_id_t    mem_q [DEPTH];
  master_id_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ID storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller; m0 (USB DMA) has priority,
// read beats are steered back to their issuer through an in-order return-ID FIFO.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_orphan_rdv
);

  localparam int HW = $clog2(MAX_HOLD);

  master_id_t    grant_q, grant_d, gnt, head_id;
  logic          lock_q, lock_d;
  logic          idle_q, idle_d;
  logic          err_q, err_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_base;
  logic          req0, req1, other_req;
  logic          g_read, g_write, g_rd, g_req, g_wait;
  logic          stall, accept, push, pop;
  logic          fifo_full, fifo_empty;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    // Simultaneous requests out of idle go to m0 regardless of where grant was parked.
    gnt  = (idle_q && req0 && req1 && !lock_q) ? M0 : grant_q;

    g_read       = (gnt == M0) ? m0_read       : m1_read;
    g_write      = (gnt == M0) ? m0_write      : m1_write;
    s_address    = (gnt == M0) ? m0_address    : m1_address;
    s_writedata  = (gnt == M0) ? m0_writedata  : m1_writedata;
    s_byteenable = (gnt == M0) ? m0_byteenable : m1_byteenable;
    other_req    = (gnt == M0) ? req1          : req0;

    g_rd   = g_read & ~g_write;
    g_req  = g_read | g_write;
    pop    = s_readdatavalid & ~fifo_empty & ~reset_reset;
    stall  = g_rd & fifo_full & ~pop;
    accept = ~reset_reset & g_req & ~s_waitrequest & ~stall;
    push   = accept & g_rd;

    s_read  = ~reset_reset & g_rd & ~stall;
    s_write = ~reset_reset & g_write;
    g_wait  = reset_reset | s_waitrequest | stall;
    m0_waitrequest = (gnt == M0) ? g_wait : 1'b1;
    m1_waitrequest = (gnt == M1) ? g_wait : 1'b1;

    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    m0_readdatavalid = pop & (head_id == M0);
    m1_readdatavalid = pop & (head_id == M1);

    hold_base  = (gnt != grant_q) ? '0 : hold_cnt_q;
    grant_d    = gnt;
    hold_cnt_d = hold_base;
    lock_d     = g_req & ~accept;
    if (!lock_d) begin
      if (accept && other_req) begin
        if (hold_base == HW'(MAX_HOLD - 1)) grant_d = other_id(gnt);
        else hold_cnt_d = hold_base + HW'(1);
      end else if (!g_req && other_req) begin
        grant_d = other_id(gnt);
      end
    end
    if (grant_d != gnt) hold_cnt_d = '0;

    idle_d = ~req0 & ~req1;
    err_d  = err_q | (s_readdatavalid & fifo_empty);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      grant_q    <= M0;
      lock_q     <= 1'b0;
      hold_cnt_q <= '0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      lock_q     <= lock_d;
      hold_cnt_q <= hold_cnt_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  assign err_orphan_rdv = err_q;

  rd_id_fifo #(
    .DEPTH(MAX_PEND),
    .PW   ($clog2(MAX_PEND))
  ) u_rd_id_fifo (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .push (push),
    .pop  (pop),
    .din  (gnt),
    .dout (head_id),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule
